// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID instruction FIFO with flush and rdy pause; zero-word bubble when empty.
// Define IFQ_BYPASS_EN for a zero-latency fetch-to-decode bypass while the queue is empty.
module if_id_queue #(
  parameter int PC_WIDTH = 17,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  input  logic if_valid,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic [INST_WIDTH-1:0] if_inst,
  output logic if_ready,
  output logic id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  input  logic id_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W = PC_WIDTH + INST_WIDTH;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] head;
  logic held, byp, wr, rd;
  always_comb begin
    head = mem[rd_ptr];
    held = rdy & ~flush & (count != '0);
`ifdef IFQ_BYPASS_EN
    byp = rdy & ~rst & ~flush & if_valid & (count == '0);
`else
    byp = 1'b0;
`endif
    if_ready = rdy & ~rst & ((count != CW'(DEPTH)) | flush);
    id_valid = held | byp;
    {id_pc, id_inst} = held ? head : (byp ? {if_pc, if_inst} : '0);
    // a bypassed entry consumed by decode this cycle never occupies a slot
    wr = if_valid & if_ready & ~flush & ~(byp & id_ready);
    rd = held & id_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(wr);
        rd_ptr <= rd_ptr + AW'(rd);
        count <= count + CW'(wr) - CW'(rd);
      end
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {if_pc, if_inst};
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized checks of if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, rdy = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [16:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic if_ready, id_valid;
  logic [16:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [48:0] q[$];

  if_id_queue #(.PC_WIDTH(17), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_ready(id_ready), .count(count));

  always #5 clk = ~clk;

  function automatic bit m_byp();
`ifdef IFQ_BYPASS_EN
    return rdy && !rst && !flush && if_valid && q.size() == 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit m_if_ready();
    return rdy && !rst && (q.size() < DEPTH || flush);
  endfunction
  function automatic bit m_id_valid();
    return (rdy && !rst && !flush && q.size() != 0) || m_byp();
  endfunction
  function automatic logic [48:0] m_id();
    return (rdy && !rst && !flush && q.size() != 0) ? q[0] : (m_byp() ? {if_pc, if_inst} : 49'd0);
  endfunction

  task automatic apply(input logic r, input logic f, input logic v, input logic [16:0] pc,
                       input logic [31:0] inst, input logic ir);
    rdy = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; id_ready = ir;
    #1;
  endtask

  task automatic advance();
    bit byp, pop, push;
    byp = m_byp();
    pop = m_id_valid() && id_ready;
    push = if_valid && m_if_ready();
    if (rdy && !rst) begin
      if (flush) q.delete();
      else begin
        if (pop && q.size() != 0) void'(q.pop_front());
        if (push && !(byp && id_ready)) q.push_back({if_pc, if_inst});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL reset_if_ready got=%0b exp=0", if_ready); end
    checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL reset_id_inst got=%0h exp=0", id_inst); end
    rst = 0;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL release_if_ready got=%0b exp=1", if_ready); end
    advance();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 17'h20 + 17'(4 * i), 32'h1000 + i, 0);
      advance();
    end
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    #1 rst = 1;
    q.delete();
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_id_valid got=%0b exp=0", id_valid); end
    checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL mid_rst_id_inst got=%0h exp=0", id_inst); end
    rst = 0;
    advance();
    apply(1, 0, 1, 17'h40, 32'hCAFE0001, 0);
    advance();
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL mid_post_count got=%0d exp=1", count); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 17'h40) begin failures++; $display("FAIL mid_post_id got=%0b/%0h exp=1/40", id_valid, id_pc); end
    apply(1, 0, 0, 0, 0, 1);
    advance();
  endtask

  task automatic test_fill_wrap();
    logic [16:0] order [6];
    order = '{17'h0, 17'h4, 17'h8, 17'hC, 17'h10, 17'h14};
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 1, order[i], $urandom, 0);
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL fill_if_ready[%0d] got=%0b exp=1", i, if_ready); end
      advance();
    end
    apply(1, 0, 1, 17'h10, 32'hDEAD, 0);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL full_if_ready got=%0b exp=0", if_ready); end
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      checks++; if (id_pc !== order[i]) begin failures++; $display("FAIL wrap_pop[%0d] got=%0h exp=%0h", i, id_pc, order[i]); end
      advance();
    end
    for (int i = 4; i < 6; i++) begin
      apply(1, 0, 1, order[i], $urandom, 0);
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL wrap_push[%0d] got=%0b exp=1", i, if_ready); end
      advance();
    end
    for (int i = 2; i < 6; i++) begin
      logic [48:0] e;
      apply(1, 0, 0, 0, 0, 1);
      e = m_id();
      checks++; if (id_pc !== order[i] || id_inst !== e[31:0]) begin failures++; $display("FAIL wrap_pop[%0d] got=%0h/%0h exp=%0h/%0h", i, id_pc, id_inst, order[i], e[31:0]); end
      advance();
    end
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 1, 17'h200 + 17'(4 * i), $urandom, 0);
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 1, 17'h208 + 17'(4 * i), $urandom, 1);
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL pp_count[%0d] got=%0d exp=2", i, count); end
      checks++; if (id_pc !== 17'h200 + 17'(4 * i)) begin failures++; $display("FAIL pp_head[%0d] got=%0h exp=%0h", i, id_pc, 17'h200 + 17'(4 * i)); end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      checks++; if (id_pc !== 17'h218 + 17'(4 * i)) begin failures++; $display("FAIL pp_drain[%0d] got=%0h exp=%0h", i, id_pc, 17'h218 + 17'(4 * i)); end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 17'h300 + 17'(4 * i), $urandom, 0);
      advance();
    end
    apply(1, 1, 1, 17'h30C, 32'h00000013, 0);
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'd0) begin failures++; $display("FAIL flush_id got=%0b/%0h exp=0/0", id_valid, id_inst); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_if_ready got=%0b exp=1", if_ready); end
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      checks++; if (count !== 3'd0 || id_valid !== 1'b0 || id_inst === 32'h13) begin failures++; $display("FAIL flush_after[%0d] got=%0d/%0b/%0h exp=0/0/0", i, count, id_valid, id_inst); end
      advance();
    end
    apply(1, 0, 1, 17'h400, 32'h12345678, 0);
    advance();
    apply(1, 0, 0, 0, 0, 1);
    checks++; if (id_pc !== 17'h400 || id_inst !== 32'h12345678) begin failures++; $display("FAIL flush_resume got=%0h/%0h exp=400/12345678", id_pc, id_inst); end
    advance();
  endtask

  task automatic test_rdy_low();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 1, 17'h500 + 17'(4 * i), $urandom, 0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 17'h508, 32'hBAD, 1);
      checks++; if (if_ready !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL rdy_hs[%0d] got=%0b/%0b exp=0/0", i, if_ready, id_valid); end
      checks++; if (id_pc !== 17'd0 || id_inst !== 32'd0) begin failures++; $display("FAIL rdy_bubble[%0d] got=%0h/%0h exp=0/0", i, id_pc, id_inst); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL rdy_count[%0d] got=%0d exp=2", i, count); end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      checks++; if (id_pc !== 17'h500 + 17'(4 * i)) begin failures++; $display("FAIL rdy_resume[%0d] got=%0h exp=%0h", i, id_pc, 17'h500 + 17'(4 * i)); end
      advance();
    end
  endtask

  task automatic test_bypass();
    apply(1, 0, 1, 17'h100, 32'h00A00093, 1);
`ifdef IFQ_BYPASS_EN
    checks++; if (id_valid !== 1'b1 || id_pc !== 17'h100 || id_inst !== 32'h00A00093) begin failures++; $display("FAIL byp_same got=%0b/%0h/%0h exp=1/100/a00093", id_valid, id_pc, id_inst); end
    advance();
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL byp_after got=%0d/%0b exp=0/0", count, id_valid); end
`else
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL nobyp_same got=%0b exp=0", id_valid); end
    advance();
    apply(1, 0, 0, 0, 0, 0);
    checks++; if (count !== 3'd1 || id_pc !== 17'h100 || id_inst !== 32'h00A00093) begin failures++; $display("FAIL nobyp_next got=%0d/%0h/%0h exp=1/100/a00093", count, id_pc, id_inst); end
    apply(1, 0, 0, 0, 0, 1);
    advance();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [48:0] e;
      apply($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
            17'($urandom), $urandom, $urandom_range(0, 9) < 5);
      e = m_id();
      checks++; if (if_ready !== m_if_ready()) begin failures++; $display("FAIL rnd_if_ready[%0d] got=%0b exp=%0b", i, if_ready, m_if_ready()); end
      checks++; if (id_valid !== m_id_valid()) begin failures++; $display("FAIL rnd_id_valid[%0d] got=%0b exp=%0b", i, id_valid, m_id_valid()); end
      checks++; if ({id_pc, id_inst} !== e) begin failures++; $display("FAIL rnd_id[%0d] got=%0h/%0h exp=%0h/%0h", i, id_pc, id_inst, e[48:32], e[31:0]); end
      checks++; if (count !== 3'(q.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill_wrap();
    test_push_pop();
    test_flush();
    test_rdy_low();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer replacing the single-entry IF/ID pipeline register between fetch and decode. It holds up to DEPTH fetched {pc, inst} pairs in a circular buffer with valid/ready handshakes on both sides. It supports a single-cycle flush on control-flow redirect and honours the global `rdy` pause. Empty slots are presented to decode as a zero-word bubble, as the existing decode stage expects.

## Interface
- PC_WIDTH, 17, width of program-counter field
- INST_WIDTH, 32, width of instruction field
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  redirect: discard all stored and incoming entries
- if_valid  in  1  fetch presents an instruction
- if_pc  in  PC_WIDTH  pc of presented instruction
- if_inst  in  INST_WIDTH  presented instruction
- if_ready  out  1  queue accepts this cycle
- id_valid  out  1  head entry valid for decode
- id_pc  out  PC_WIDTH  head pc; 0 when id_valid=0
- id_inst  out  INST_WIDTH  head instruction; 0 when id_valid=0
- id_ready  in  1  decode consumes head this cycle
- count  out  $clog2(DEPTH+1)  stored entries

## Operation
- State: storage array, wr_ptr and rd_ptr of $clog2(DEPTH) bits (wrap naturally at DEPTH), and count.
- Reset (async): wr_ptr, rd_ptr and count go to 0; storage contents are don't-care. Outputs: id_valid=0, id_pc=0, id_inst=0. if_ready=0 while rst is high.
- Push = if_valid & if_ready. Pop = id_valid & id_ready.
- if_ready = rdy & ~rst & (count < DEPTH | flush). When full, there is no pass-through, even if a pop occurs in the same cycle.
- id_valid = rdy & ~flush & (count != 0). Head = storage[rd_ptr].
- Push only: write at wr_ptr, then wr_ptr+1 and count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop together: both pointers advance and count is unchanged.
- flush at a rising edge with rdy=1: ptrs=0 and count=0. Any simultaneous push is accepted on the handshake but dropped. No pop occurs (id_valid is already 0).
- rdy=0: no state change. if_ready=0, id_valid=0, and the id outputs are zero.

## Timing
- Default latency: an entry pushed at edge N is visible on id_* after edge N, i.e. in cycle N+1.
- Throughput is one push and one pop per cycle. Sustained flow at count=1 gives a steady one-cycle latency.
- id_* and if_ready are combinational from registered state plus rdy, rst and flush. There is no combinational path from if_* to id_* unless the bypass option is enabled.
- A flush asserted in cycle N blanks id_valid in cycle N. The queue is empty in cycle N+1.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count=0, if_valid=1, rdy=1 and flush=0, if_* drives id_* combinationally and id_valid=1 in the same cycle.
  - If id_ready=1, the entry is consumed and not written. Otherwise it is written normally.
  - Zero-latency when empty.
- IFQ_BYPASS_EN undefined: behaviour is exactly as in Operation, with one-cycle minimum latency.

## Test plan
- Reset mid-stream:
  - Stimulus: push 3 entries, then pulse rst asynchronously between edges.
  - Response: count=0, id_valid=0 and id_inst=0 immediately. A push after release appears at id with count=1.
- Fill and wrap (DEPTH=4, id_ready=0):
  - Stimulus: push pc 0x0,0x4,0x8,0xC, then attempt 0x10.
  - Response: if_ready=0 and count=4.
  - Then: pop 2 and push 0x10, 0x14.
  - Response: pop order is 0x0,0x4,0x8,0xC,0x10,0x14, with correct wrap of wr_ptr.
- Simultaneous push and pop at count=2:
  - Response: count stays 2 and head advances by one entry per cycle for 6 cycles.
- Flush with concurrent push at count=3:
  - Stimulus: assert flush while pushing inst 0x00000013.
  - Response: id_valid=0 that cycle. Next cycle count=0, and 0x00000013 never appears.
- rdy low for 3 cycles with if_valid=1 and id_ready=1:
  - Response: count and pointers unchanged, if_ready=0, id_valid=0. Flow resumes identically when rdy returns to 1.
- Bypass (IFQ_BYPASS_EN, empty, id_ready=1):
  - Stimulus: push inst 0x00A00093, pc 0x100.
  - Response: id_valid=1, id_pc=0x100 same cycle; count stays 0.
  - Without the macro: id shows the entry one cycle later, with count=1 in between.
